// File: rtl/sseg_pkg.sv
// Shared segment encodings for the seven-segment scan driver.
// Bit order is abcdefg with a as the MSB; all patterns are active-low.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational nibble to active-low segment decoder.
// Define SSEG_HEX_EN to show A-F; otherwise 10-15 decode as blank.
module sseg_digit_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
`ifdef SSEG_HEX_EN
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
`endif
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver with shadowed digits, per-digit blink and enable.
// Hex glyphs for 10-15 are enabled by defining SSEG_HEX_EN (see sseg_digit_decode).
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 128
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic                    load,
   input  logic                    ena,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              sseg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CW-1:0]              scan_cnt;
   logic [IW-1:0]              idx;
   logic [FW-1:0]              frame_cnt;
   logic                       blink_phase;
   logic [NUM_DIGITS-1:0][3:0] shadow;

   logic                       tc;
   logic                       wrap;
   logic                       visible;
   logic [3:0]                 nib;
   logic [6:0]                 seg_dec;
   logic [NUM_DIGITS-1:0]      an_nxt;

   assign tc      = (scan_cnt == CW'(SCAN_DIV - 1));
   assign wrap    = tc && (idx == IW'(NUM_DIGITS - 1));
   assign visible = ena && !(blink_phase && blink_mask[idx]);
   assign nib     = shadow[idx];

   sseg_digit_decode u_dec (
      .nib (nib),
      .seg (seg_dec)
   );

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
      assign an_nxt[i] = !(visible && (idx == IW'(i)));
   end

   // Scan timing, blink phase and shadow keep running even while the display is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt    <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         shadow      <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (load) shadow <= digits;
         if (tc) begin
            scan_cnt <= '0;
            idx      <= wrap ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (wrap) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Outputs follow idx/shadow by one cycle, so a load on an advance edge shows in the new slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sseg <= SEG_BLANK;
         an   <= '1;
      end else begin
         sseg <= visible ? seg_dec : SEG_BLANK;
         an   <= an_nxt;
      end
   end

endmodule
